// File: rtl/brq_arb_pkg.sv
// rtl/brq_arb_pkg.sv - shared owner enum and byte-strobe width for the memory arbiter
package brq_arb_pkg;

  localparam int BeWidth = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IFU  = 2'd1,
    OWN_LDST = 2'd2
  } owner_e;

endpackage

// File: rtl/brq_arb_fair_cnt.sv
// rtl/brq_arb_fair_cnt.sv - saturating count of data grants made while a fetch waits
module brq_arb_fair_cnt #(
  parameter int MaxDataRun = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ifu_req,
  input  logic ifu_gnt,
  input  logic ldst_gnt,
  output logic force_ifu
);

  localparam int CntWidth = $clog2(MaxDataRun + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxDataRun);

  logic [CntWidth-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!ifu_req || ifu_gnt) begin
      cnt <= '0;
    end else if (ldst_gnt && (cnt != CntMax)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Once the data side has had its run, the waiting fetch wins the next cycle.
  assign force_ifu = ifu_req && (cnt == CntMax);

endmodule

// File: rtl/brq_mem_arbiter.sv
// rtl/brq_mem_arbiter.sv - fetch/data arbiter for a 1-cycle single-port memory; BRQ_ARB_FAIRNESS_EN adds fetch fairness
module brq_mem_arbiter
  import brq_arb_pkg::*;
#(
  parameter int DataWidth  = 32,
  parameter int AddrWidth  = 15,
  parameter int MaxDataRun = 4
) (
  input  logic                 brq_clk,
  input  logic                 brq_rst,
  input  logic                 ifu_req,
  input  logic [AddrWidth-1:0] ifu_addr,
  output logic                 ifu_gnt,
  output logic                 ifu_rvalid,
  output logic [DataWidth-1:0] ifu_rdata,
  input  logic                 ldst_req,
  input  logic                 ldst_we,
  input  logic [AddrWidth-1:0] ldst_addr,
  input  logic [DataWidth-1:0] ldst_wdata,
  input  logic [BeWidth-1:0]   ldst_be,
  output logic                 ldst_gnt,
  output logic                 ldst_rvalid,
  output logic [DataWidth-1:0] ldst_rdata,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [AddrWidth-1:0] mem_addr,
  output logic [DataWidth-1:0] mem_wdata,
  output logic [BeWidth-1:0]   mem_be,
  input  logic [DataWidth-1:0] mem_rdata,
  output logic                 arb_stall
);

  logic   ldst_win;
  logic   ifu_win;
  owner_e owner;

  if (MaxDataRun < 1) begin : g_bad_cfg
    $error("MaxDataRun must be at least 1");
  end

`ifdef BRQ_ARB_FAIRNESS_EN
  logic force_ifu;

  brq_arb_fair_cnt #(
    .MaxDataRun(MaxDataRun)
  ) u_fair_cnt (
    .clk      (brq_clk),
    .rst      (brq_rst),
    .ifu_req  (ifu_req),
    .ifu_gnt  (ifu_gnt),
    .ldst_gnt (ldst_gnt),
    .force_ifu(force_ifu)
  );

  assign ldst_win = ldst_req && !force_ifu;
`else
  assign ldst_win = ldst_req;
`endif

  assign ifu_win  = ifu_req && !ldst_win;

  // Grants are held off during reset so every output reads 0.
  assign ldst_gnt  = ldst_win && !brq_rst;
  assign ifu_gnt   = ifu_win && !brq_rst;
  assign arb_stall = !brq_rst && ((ifu_req && !ifu_gnt) || (ldst_req && !ldst_gnt));

  assign mem_req   = ifu_gnt || ldst_gnt;
  assign mem_we    = ldst_gnt && ldst_we;
  assign mem_addr  = ldst_gnt ? ldst_addr : (ifu_gnt ? ifu_addr : '0);
  assign mem_wdata = ldst_gnt ? ldst_wdata : '0;
  assign mem_be    = ldst_gnt ? ldst_be : '0;

  always_ff @(posedge brq_clk or posedge brq_rst) begin
    if (brq_rst) begin
      owner       <= OWN_NONE;
      ifu_rvalid  <= 1'b0;
      ldst_rvalid <= 1'b0;
    end else if (ldst_gnt && !ldst_we) begin
      owner       <= OWN_LDST;
      ifu_rvalid  <= 1'b0;
      ldst_rvalid <= 1'b1;
    end else if (ifu_gnt) begin
      owner       <= OWN_IFU;
      ifu_rvalid  <= 1'b1;
      ldst_rvalid <= 1'b0;
    end else begin
      owner       <= OWN_NONE;
      ifu_rvalid  <= 1'b0;
      ldst_rvalid <= 1'b0;
    end
  end

  assign ifu_rdata  = (owner == OWN_IFU)  ? mem_rdata : '0;
  assign ldst_rdata = (owner == OWN_LDST) ? mem_rdata : '0;

endmodule
